// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the 16-bit external bus master.
// Also holds the write lane packing used when a request is accepted.
package ext_bus_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;

    localparam logic [BE_W-1:0] BE_NONE = 2'b00;
    localparam logic [BE_W-1:0] BE_LO   = 2'b01;
    localparam logic [BE_W-1:0] BE_HI   = 2'b10;
    localparam logic [BE_W-1:0] BE_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_e;

    // Single-byte writes always travel on the low lane of write_data.
    function automatic logic [DATA_W-1:0] pack_write(input logic [BE_W-1:0]   be,
                                                     input logic [DATA_W-1:0] wd);
        logic [DATA_W-1:0] packed_v;
        case (be)
            BE_LO:   packed_v = {8'h00, wd[7:0]};
            BE_HI:   packed_v = {8'h00, wd[15:8]};
            BE_WORD: packed_v = wd;
            default: packed_v = 16'h0000;
        endcase
        return packed_v;
    endfunction

endpackage

// File: rtl/ext_bus_timeout.sv
// Saturating access-duration counter; expired_o flags the last allowed cycle.
// A LIMIT of 0 disables expiry entirely.
module ext_bus_timeout #(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned W     = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned   LAST   = (LIMIT == 0) ? 0 : LIMIT - 1;
    localparam logic [W-1:0]  LAST_V = W'(LAST);
    localparam logic [W-1:0]  MAX_V  = {W{1'b1}};
    localparam logic [W-1:0]  ONE_V  = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise increment without wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + ONE_V;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (LIMIT != 0) && (cnt_q == LAST_V);

endmodule

// File: rtl/external_bus_master.sv
// One-request-at-a-time initiator for the 16-bit external bus with timeout.
// Every output is a register loaded from the next-state decode.
module external_bus_master
    import ext_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_address,
    input  logic              req_rw,
    input  logic [BE_W-1:0]   req_byte_enable,
    input  logic [DATA_W-1:0] req_write_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_read_data,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] address,
    output logic              bus_enable,
    output logic [BE_W-1:0]   byte_enable,
    output logic              rw,
    output logic [DATA_W-1:0] write_data,
    input  logic              acknowledge,
    input  logic [DATA_W-1:0] read_data
);

    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W = (CNT_RAW < 1) ? 1 : CNT_RAW;

    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_error_q, rsp_error_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic                bus_enable_q, bus_enable_d;
    logic [BE_W-1:0]     byte_enable_q, byte_enable_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                start_s, count_en_s, expired_s;

    ext_bus_timeout #(.LIMIT(TIMEOUT_CYCLES), .W(CNT_W)) u_timeout (
        .clk_i     (clk_clk),
        .rst_ni    (reset_reset_n),
        .clear_i   (start_s),
        .en_i      (count_en_s),
        .expired_o (expired_s)
    );

    assign count_en_s = (state_q == ACCESS) && !acknowledge && !expired_s;

    // Next-state and next-output decode; bus is parked as an idle read outside ACCESS.
    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        write_data_d  = write_data_q;
        bus_enable_d  = 1'b0;
        byte_enable_d = BE_NONE;
        rw_d          = 1'b1;
        rsp_data_d    = rsp_data_q;
        rsp_error_d   = rsp_error_q;
        start_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (req_byte_enable != BE_NONE) begin
                        state_d       = ACCESS;
                        start_s       = 1'b1;
                        address_d     = req_address;
                        bus_enable_d  = 1'b1;
                        byte_enable_d = req_byte_enable;
                        rw_d          = req_rw;
                        if (!req_rw) begin
                            write_data_d = pack_write(req_byte_enable, req_write_data);
                        end else begin
                            write_data_d = write_data_q;
                        end
                    end else begin
                        state_d     = RESPOND;
                        rsp_error_d = 1'b1;
                        rsp_data_d  = 16'h0000;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // Acknowledge is checked first so it beats a simultaneous expiry.
                if (acknowledge) begin
                    state_d     = RESPOND;
                    rsp_error_d = 1'b0;
                    rsp_data_d  = rw_q ? read_data : 16'h0000;
                end else if (expired_s) begin
                    state_d     = RESPOND;
                    rsp_error_d = 1'b1;
                    rsp_data_d  = 16'h0000;
                end else begin
                    state_d       = ACCESS;
                    bus_enable_d  = 1'b1;
                    byte_enable_d = byte_enable_q;
                    rw_d          = rw_q;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready_d = (state_d == IDLE);
    assign rsp_valid_d = (state_d == RESPOND);

    // State and output registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 16'h0000;
            rsp_error_q   <= 1'b0;
            address_q     <= 19'h00000;
            bus_enable_q  <= 1'b0;
            byte_enable_q <= BE_NONE;
            rw_q          <= 1'b1;
            write_data_q  <= 16'h0000;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_error_q   <= rsp_error_d;
            address_q     <= address_d;
            bus_enable_q  <= bus_enable_d;
            byte_enable_q <= byte_enable_d;
            rw_q          <= rw_d;
            write_data_q  <= write_data_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_read_data = rsp_data_q;
    assign rsp_error     = rsp_error_q;
    assign address       = address_q;
    assign bus_enable    = bus_enable_q;
    assign byte_enable   = byte_enable_q;
    assign rw            = rw_q;
    assign write_data    = write_data_q;

endmodule

// File: tb/tb_external_bus_master.sv
// Scoreboard bench for external_bus_master against a four-register peripheral model.
`timescale 1ns/1ps
module tb_external_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [18:0] req_address = 19'h0;
    logic        req_rw = 1'b1;
    logic [1:0]  req_byte_enable = 2'b00;
    logic [15:0] req_write_data = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_read_data;
    logic        rsp_error;
    logic [18:0] address;
    logic        bus_enable;
    logic [1:0]  byte_enable;
    logic        rw;
    logic [15:0] write_data;
    logic        acknowledge;
    logic [15:0] read_data;

    logic [15:0] mem [4] = '{default: 16'h0000};
    int          be_cnt = 0;
    int          ack_delay = 0;
    logic        ack_force = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int be_run = 0;
    int be_len = 0;
    int overlap_cnt = 0;
    int acc_cyc[$];

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    external_bus_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_address     (req_address),
        .req_rw          (req_rw),
        .req_byte_enable (req_byte_enable),
        .req_write_data  (req_write_data),
        .rsp_valid       (rsp_valid),
        .rsp_read_data   (rsp_read_data),
        .rsp_error       (rsp_error),
        .address         (address),
        .bus_enable      (bus_enable),
        .byte_enable     (byte_enable),
        .rw              (rw),
        .write_data      (write_data),
        .acknowledge     (acknowledge),
        .read_data       (read_data)
    );

    // Peripheral: acknowledges ack_delay cycles into the access (never when negative).
    assign acknowledge = ack_force | (bus_enable && (ack_delay >= 0) && (be_cnt == ack_delay));
    assign read_data   = mem[address[18:17]];

    always @(posedge clk) begin
        if (!bus_enable) be_cnt <= 0;
        else             be_cnt <= be_cnt + 1;
        if (bus_enable && acknowledge && !rw) begin
            case (byte_enable)
                2'b01:   mem[address[18:17]][7:0]  <= write_data[7:0];
                2'b10:   mem[address[18:17]][15:8] <= write_data[7:0];
                2'b11:   mem[address[18:17]]       <= write_data;
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic [15:0] d, input logic e);
        rsp_t r;
        r.data = d;
        r.err  = e;
        exp_q.push_back(r);
    endtask

    // Drives a request and returns one time unit after the accepting edge.
    task automatic send(input logic [18:0] a, input logic r, input logic [1:0] be, input logic [15:0] wd);
        int n;
        req_valid = 1'b1;
        req_address = a;
        req_rw = r;
        req_byte_enable = be;
        req_write_data = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready %0b expected 1", req_ready);
        end else begin
            tick();
        end
    endtask

    task automatic drain();
        int n;
        req_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        tick();
    endtask

    // Response monitor and bus observer.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got data %0h err %0b expected no response", rsp_read_data, rsp_error);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_read_data, e.data);
                    check("rsp_error", rsp_error, e.err);
                end
            end
            if (bus_enable && rsp_valid) overlap_cnt++;
            if (!bus_enable) begin
                check("idle_rw", rw, 1);
                check("idle_be", byte_enable, 0);
            end
            if (bus_enable) be_run++;
            else if (be_run != 0) begin
                be_len = be_run;
                be_run = 0;
            end
            if (req_valid && req_ready) acc_cyc.push_back(cyc);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset values while in reset.
        #12;
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_bus_enable", bus_enable, 0);
        check("rst_rw", rw, 1);
        check("rst_address", address, 0);
        #10 rst_n = 1'b1;
        tick();
        check("ready_after_rst", req_ready, 1);

        // Word write then read back, accept-to-accept spacing.
        expect_rsp(16'h0000, 1'b0);
        send(19'h20000, 1'b0, 2'b11, 16'hBEEF);
        check("w_bus_enable", bus_enable, 1);
        check("w_rw", rw, 0);
        check("w_write_data", write_data, 16'hBEEF);
        check("w_byte_enable", byte_enable, 2'b11);
        check("w_address", address, 19'h20000);
        expect_rsp(16'hBEEF, 1'b0);
        send(19'h20000, 1'b1, 2'b11, 16'h0000);
        check("r_rw", rw, 1);
        drain();
        check("accept_spacing", acc_cyc[1] - acc_cyc[0], 3);
        check("w_be_len", be_len, 1);

        // High-byte write travels on the low lane.
        expect_rsp(16'h0000, 1'b0);
        send(19'h20000, 1'b0, 2'b10, 16'hA55A);
        check("hb_write_data", write_data, 16'h00A5);
        check("hb_byte_enable", byte_enable, 2'b10);
        expect_rsp(16'hA5EF, 1'b0);
        send(19'h20000, 1'b1, 2'b11, 16'h0000);
        drain();

        // Timeout with no acknowledge.
        ack_delay = -1;
        expect_rsp(16'h0000, 1'b1);
        send(19'h00000, 1'b1, 2'b11, 16'h0000);
        req_valid = 1'b0;
        n = 0;
        while (bus_enable && n < 20) begin
            n++;
            tick();
        end
        check("to_be_cycles", n, 4);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rw", rw, 1);
        drain();

        // Acknowledge on the cycle the timeout would fire wins.
        ack_delay = 3;
        expect_rsp(16'hA5EF, 1'b0);
        send(19'h20000, 1'b1, 2'b01, 16'h0000);
        req_valid = 1'b0;
        n = 0;
        while (bus_enable && n < 20) begin
            n++;
            tick();
        end
        check("late_ack_cycles", n, 4);
        drain();

        // Illegal byte enable: no bus cycle, error response next cycle.
        ack_delay = 0;
        expect_rsp(16'h0000, 1'b1);
        send(19'h20000, 1'b0, 2'b00, 16'hFFFF);
        req_valid = 1'b0;
        check("ill_no_bus", bus_enable, 0);
        check("ill_rsp_valid", rsp_valid, 1);
        drain();

        // Acknowledge outside an access is ignored.
        ack_force = 1'b1;
        tick();
        tick();
        check("stray_ack_rsp", rsp_valid, 0);
        ack_force = 1'b0;
        tick();

        // Back-to-back requests with valid held high.
        acc_cyc.delete();
        overlap_cnt = 0;
        expect_rsp(16'h0000, 1'b0);
        send(19'h40000, 1'b0, 2'b11, 16'h1234);
        expect_rsp(16'h0000, 1'b0);
        send(19'h60000, 1'b0, 2'b01, 16'h5678);
        check("b2b_lo_write_data", write_data, 16'h0078);
        expect_rsp(16'h1234, 1'b0);
        send(19'h40000, 1'b1, 2'b11, 16'h0000);
        expect_rsp(16'h0078, 1'b0);
        send(19'h60000, 1'b1, 2'b11, 16'h0000);
        drain();
        for (int i = 1; i < 4; i++) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
        check("b2b_overlap", overlap_cnt, 0);

        // Reset in the middle of an access.
        ack_delay = -1;
        send(19'h20000, 1'b1, 2'b11, 16'h0000);
        req_valid = 1'b0;
        check("mid_bus_enable_before", bus_enable, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_bus_enable", bus_enable, 0);
        check("mid_rw", rw, 1);
        check("mid_ready", req_ready, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_ready", req_ready, 1);
        ack_delay = 0;
        expect_rsp(16'hA5EF, 1'b0);
        send(19'h20000, 1'b1, 2'b11, 16'h0000);
        drain();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/external_bus_master.md
# external_bus_master

Initiator for the 16-bit external bus, driving `address`, `bus_enable`, `byte_enable`, `rw` and `write_data` toward register peripherals and collecting `acknowledge` and `read_data`. It accepts one request at a time from an internal ready/valid request port and performs exactly one bus access per request. It returns a single-cycle response carrying read data or an error, and an access aborts with an error if no acknowledge arrives within a bounded timeout. It sits between the system interconnect and the external bus pins.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles `bus_enable` stays high without `acknowledge`. 0 disables the timeout (wait forever).
- `clk_clk` in 1: single clock, rising edge.
- `reset_reset_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts a request this cycle.
- `req_address` in 19: bus address. Bits [18:17] select the peripheral register.
- `req_rw` in 1: 1 = read, 0 = write.
- `req_byte_enable` in 2: lane enables. Bit 0 = [7:0], bit 1 = [15:8].
- `req_write_data` in 16: write data in natural lane positions.
- `rsp_valid` out 1: one-cycle response pulse. There is no backpressure.
- `rsp_read_data` out 16: read data, valid with `rsp_valid`.
- `rsp_error` out 1: timeout or illegal request, valid with `rsp_valid`.
- `address` out 19, `bus_enable` out 1, `byte_enable` out 2, `rw` out 1, `write_data` out 16: external bus drive. All are registered.
- `acknowledge` in 1, `read_data` in 16: external bus return.

## Operation
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid` with `req_byte_enable` != 2'b00: latch the request, drive the bus registers, go to ACCESS.
  - On `req_valid` with `req_byte_enable` == 2'b00: no bus cycle. Go to RESPOND with error = 1 and data = 16'h0000.
- ACCESS:
  - `bus_enable` = 1. Address, `rw` and `byte_enable` are held stable.
  - If `acknowledge` = 1: capture `read_data` when `rw` = 1, otherwise 16'h0000. Clear `bus_enable` and go to RESPOND with error = 0.
  - Else if the timeout counter equals `TIMEOUT_CYCLES`-1 (timeout enabled): clear `bus_enable` and go to RESPOND with error = 1 and data = 16'h0000.
  - Else increment the counter.
- RESPOND: `rsp_valid` = 1 for exactly this cycle, `req_ready` = 0, then go to IDLE.
- Write lane packing follows the peripheral convention that single-byte data travels on `write_data[7:0]`:
  - `byte_enable` 2'b01 → `write_data` = {8'h00, req_write_data[7:0]}.
  - 2'b10 → {8'h00, req_write_data[15:8]}.
  - 2'b11 → `req_write_data` unchanged.
- Reads return all 16 bits of `read_data` unmodified, regardless of byte enables.
- While not in ACCESS: `bus_enable` = 0, `rw` = 1 (read, so no stray write occurs), `byte_enable` = 2'b00. `address` and `write_data` hold their last values.
- Timeout counter: width ⌈log2(TIMEOUT_CYCLES+1)⌉, minimum 1 bit. Cleared on entry to ACCESS and saturates (never wraps).

## Timing
- Reset values: `req_ready` 0 during reset and 1 in the first cycle after release. All other outputs are 0 except `rw` = 1. FSM resets to IDLE and the counter to 0.
- A request is accepted at edge E0 (`req_valid` & `req_ready`).
- E0..E1: `bus_enable` high. Peripherals acknowledge combinationally, so `acknowledge` is sampled, and a write commits, at edge E1.
- E1..E2: `rsp_valid` high.
- From E2: `req_ready` high again. Minimum 3 cycles per transaction.
- Timeout path: `bus_enable` is high for exactly `TIMEOUT_CYCLES` cycles, then `rsp_valid` with `rsp_error` = 1 follows one cycle later.
- If `acknowledge` arrives in the same cycle the timeout would fire, the acknowledge wins (error = 0).
- `acknowledge` seen outside ACCESS is ignored.
- Reset asserted mid-transaction: all outputs go to reset values immediately (asynchronously), no response is issued, and the request is lost.

## Structure
- Shared package `ext_bus_pkg`:
  - FSM state enum.
  - Bus width constants: ADDR_W = 19, DATA_W = 16, BE_W = 2.
  - Byte-enable encodings BE_NONE, BE_LO, BE_HI, BE_WORD.
- Optional sub-module `ext_bus_timeout`: loadable saturating counter with enable and expiry flag.
- Everything else is in one module.

## Test plan
- Word write then read:
  - Write `req_address` 19'h20000, byte enables 2'b11, data 16'hBEEF → one cycle of `bus_enable` with `rw` = 0 and `write_data` 16'hBEEF, then `rsp_valid` with error = 0.
  - Read the same address → `rsp_read_data` 16'hBEEF, 3 cycles accept-to-accept.
- High-byte write:
  - Byte enables 2'b10, `req_write_data` 16'hA55A → `write_data` 16'h00A5, `byte_enable` 2'b10.
  - Read back shows only [15:8] changed to A5.
- Timeout:
  - `TIMEOUT_CYCLES` = 4, `acknowledge` tied low → `bus_enable` high for exactly 4 cycles, then `rsp_valid` with `rsp_error` = 1 and data 16'h0000.
  - `rw` returns to 1.
- Illegal byte enable: 2'b00 → no `bus_enable` pulse, `rsp_valid` with `rsp_error` = 1 on the cycle after accept.
- Reset mid-access: assert `reset_reset_n` = 0 between clock edges while `bus_enable` = 1 → `bus_enable` drops immediately and no `rsp_valid` is issued. After release, `req_ready` = 1 and a new read completes normally.
- Back-to-back: `req_valid` held high for 4 requests → `req_ready` pulses every 3 cycles, responses arrive in order, no bus overlap.
